// File: rtl/pulse_stretch_multi.sv
// rtl/pulse_stretch_multi.sv - per-lane pulse-to-level stretcher with optional retrigger
// Each lane holds level_out high for HOLD cycles per trigger; busy mirrors |level_out.
module pulse_stretch_multi #(
  parameter int WIDTH  = 8,
  parameter int HOLD   = 4,
  parameter int CNT_W  = 4,
  parameter int RETRIG = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic             clr_drop,
  output logic [WIDTH-1:0] level_out,
  output logic             busy,
  output logic [WIDTH-1:0] drop_sticky
);

  typedef enum logic {IDLE = 1'b0, HOLDING = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state    [WIDTH];
  state_t           state_nx [WIDTH];
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_nx   [WIDTH];
  logic [WIDTH-1:0] drop_nx;
  logic [WIDTH-1:0] level_nx;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      drop_sticky <= '0;
      busy        <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      drop_sticky <= drop_nx;
      busy        <= |level_nx;
    end
  end

  always_comb begin
    drop_nx  = '0;
    level_nx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      drop_nx[i]  = clr_drop ? 1'b0 : drop_sticky[i];
      case (state[i])
        IDLE: begin
          if (pulse_in[i]) begin
            state_nx[i] = HOLDING;
            cnt_nx[i]   = RELOAD;
          end
        end
        HOLDING: begin
          // A pulse on the final cycle (cnt==0) always chains, regardless of RETRIG.
          if (pulse_in[i] && (RETRIG != 0 || cnt[i] == '0)) begin
            cnt_nx[i] = RELOAD;
          end else if (pulse_in[i]) begin
            cnt_nx[i]  = cnt[i] - ONE;
            drop_nx[i] = 1'b1;
          end else if (cnt[i] == '0) begin
            state_nx[i] = IDLE;
          end else begin
            cnt_nx[i] = cnt[i] - ONE;
          end
        end
        default: state_nx[i] = IDLE;
      endcase
      level_nx[i] = (state_nx[i] == HOLDING);
    end
  end

  always_comb begin
    level_out = '0;
    for (int i = 0; i < WIDTH; i++) level_out[i] = (state[i] == HOLDING);
  end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// tb/tb_pulse_stretch_multi.sv - directed vector bench for pulse_stretch_multi
// Three instances share stimulus: HOLD=4/RETRIG=1, HOLD=4/RETRIG=0, HOLD=1/RETRIG=1.
module tb_pulse_stretch_multi;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] pulse_in;
  logic       clr_drop;
  logic [7:0] level_r1, level_r0, level_h1;
  logic [7:0] drop_r1, drop_r0, drop_h1;
  logic       busy_r1, busy_r0, busy_h1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_stretch_multi #(.WIDTH(8), .HOLD(4), .CNT_W(4), .RETRIG(1)) u_r1 (
    .clk(clk), .arst(arst), .pulse_in(pulse_in), .clr_drop(clr_drop),
    .level_out(level_r1), .busy(busy_r1), .drop_sticky(drop_r1));

  pulse_stretch_multi #(.WIDTH(8), .HOLD(4), .CNT_W(4), .RETRIG(0)) u_r0 (
    .clk(clk), .arst(arst), .pulse_in(pulse_in), .clr_drop(clr_drop),
    .level_out(level_r0), .busy(busy_r0), .drop_sticky(drop_r0));

  pulse_stretch_multi #(.WIDTH(8), .HOLD(1), .CNT_W(4), .RETRIG(1)) u_h1 (
    .clk(clk), .arst(arst), .pulse_in(pulse_in), .clr_drop(clr_drop),
    .level_out(level_h1), .busy(busy_h1), .drop_sticky(drop_h1));

  typedef struct {
    logic [7:0] pulse;
    logic       clr;
    logic [7:0] l_r1;
    logic [7:0] l_r0;
    logic [7:0] d_r0;
    logic [7:0] l_h1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] p, input logic c, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] d, input logic [7:0] h);
    vec_t v;
    v.pulse = p; v.clr = c; v.l_r1 = a; v.l_r0 = b; v.d_r0 = d; v.l_h1 = h;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name, input int idx);
    chk({name, "_level_r1"}, idx, level_r1, 8'h00);
    chk({name, "_level_r0"}, idx, level_r0, 8'h00);
    chk({name, "_level_h1"}, idx, level_h1, 8'h00);
    chk({name, "_busy"}, idx, {5'd0, busy_r1, busy_r0, busy_h1}, 8'h00);
    chk({name, "_drop_r0"}, idx, drop_r0, 8'h00);
  endtask

  initial begin
    // single pulse lane0
    add(8'h01, 0, 8'h01, 8'h01, 8'h00, 8'h01);
    add(8'h00, 0, 8'h01, 8'h01, 8'h00, 8'h00);
    add(8'h00, 0, 8'h01, 8'h01, 8'h00, 8'h00);
    add(8'h00, 0, 8'h01, 8'h01, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // lane3 pulses at N and N+2: retrigger vs drop
    add(8'h08, 0, 8'h08, 8'h08, 8'h00, 8'h08);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h08, 0, 8'h08, 8'h08, 8'h08, 8'h08);
    add(8'h00, 0, 8'h08, 8'h08, 8'h08, 8'h00);
    add(8'h00, 0, 8'h08, 8'h00, 8'h08, 8'h00);
    add(8'h00, 0, 8'h08, 8'h00, 8'h08, 8'h00);
    add(8'h00, 0, 8'h00, 8'h00, 8'h08, 8'h00);
    add(8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    // lane3 pulse on the cnt==0 cycle chains into an 8-cycle window
    add(8'h08, 0, 8'h08, 8'h08, 8'h00, 8'h08);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h08, 0, 8'h08, 8'h08, 8'h00, 8'h08);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // multi-lane simultaneous trigger
    add(8'hA5, 0, 8'hA5, 8'hA5, 8'h00, 8'hA5);
    add(8'h00, 0, 8'hA5, 8'hA5, 8'h00, 8'h00);
    add(8'h00, 0, 8'hA5, 8'hA5, 8'h00, 8'h00);
    add(8'h00, 0, 8'hA5, 8'hA5, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // drop set wins over clr_drop on the same edge
    add(8'h02, 0, 8'h02, 8'h02, 8'h00, 8'h02);
    add(8'h02, 1, 8'h02, 8'h02, 8'h02, 8'h02);
    add(8'h00, 1, 8'h02, 8'h02, 8'h00, 8'h00);
    add(8'h00, 0, 8'h02, 8'h02, 8'h00, 8'h00);
    add(8'h00, 0, 8'h02, 8'h00, 8'h00, 8'h00);
    add(8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    arst = 1'b1;
    pulse_in = 8'h00;
    clr_drop = 1'b0;

    // reset held while inputs toggle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pulse_in = (k % 2 == 0) ? 8'hFF : 8'h00;
      @(posedge clk);
      #1;
      chk_all_zero("reset_hold", k);
    end
    @(negedge clk);
    pulse_in = 8'h00;
    arst = 1'b0;

    // reset asserted mid-window aborts immediately
    @(negedge clk);
    pulse_in = 8'h01;
    @(posedge clk);
    #1;
    chk("midwin_start", 0, level_r1, 8'h01);
    @(negedge clk);
    pulse_in = 8'h00;
    #2;
    arst = 1'b1;
    #1;
    chk_all_zero("midwin_async", 0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midwin_release", 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      pulse_in = vecs[i].pulse;
      clr_drop = vecs[i].clr;
      @(posedge clk);
      #1;
      chk("vec_level_r1", i, level_r1, vecs[i].l_r1);
      chk("vec_busy_r1", i, {7'd0, busy_r1}, {7'd0, |vecs[i].l_r1});
      chk("vec_drop_r1", i, drop_r1, 8'h00);
      chk("vec_level_r0", i, level_r0, vecs[i].l_r0);
      chk("vec_busy_r0", i, {7'd0, busy_r0}, {7'd0, |vecs[i].l_r0});
      chk("vec_drop_r0", i, drop_r0, vecs[i].d_r0);
      chk("vec_level_h1", i, level_h1, vecs[i].l_h1);
      chk("vec_busy_h1", i, {7'd0, busy_h1}, {7'd0, |vecs[i].l_h1});
    end

    // lane7 held high for 10 sampled edges
    @(negedge clk);
    clr_drop = 1'b1;
    pulse_in = 8'h00;
    @(negedge clk);
    clr_drop = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      pulse_in = (k < 10) ? 8'h80 : 8'h00;
      @(posedge clk);
      #1;
      chk("held_r1", k, level_r1, (k < 13) ? 8'h80 : 8'h00);
      chk("held_r0", k, level_r0, (k < 12) ? 8'h80 : 8'h00);
      chk("held_h1", k, level_h1, (k < 10) ? 8'h80 : 8'h00);
      chk("held_drop_r0", k, drop_r0, (k >= 1) ? 8'h80 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
